// File: rtl/arb_pkg.sv
// Shared types and helpers for the arb_* arbiter family.
package arb_pkg;

  typedef enum logic {ARB, LOCK} arb_st_e;

  // Index width for an n-entry requester vector; never zero.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_ptr_pick.sv
// Rotating-priority picker: one-hot grant to the first request at or above ptr, wrapping.
module arb_ptr_pick #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]         req,
  input  logic [$clog2(WIDTH)-1:0] ptr,
  output logic [WIDTH-1:0]         gnt
);

  localparam int unsigned IW = $clog2(WIDTH);

  always_comb begin
    logic [IW-1:0] idx;
    idx = '0;
    gnt = '0;
    // Scan from the farthest offset down so the nearest request overwrites the rest.
    for (int off = int'(WIDTH) - 1; off >= 0; off--) begin
      idx = IW'((32'(ptr) + 32'(off)) % WIDTH);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_wrr_pkt.sv
// Weighted round-robin packet arbiter: credit-limited packets per round, locks the channel
// from first beat to last, registered single-channel output.
module arb_wrr_pkt
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PLD_WIDTH = 32,
  parameter int unsigned WGT_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         v_vld_s,
  output logic [WIDTH-1:0]         v_rdy_s,
  input  logic [PLD_WIDTH-1:0]     v_pld_s    [WIDTH-1:0],
  input  logic [WIDTH-1:0]         v_last_s,
  input  logic [WGT_W-1:0]         cfg_weight [WIDTH-1:0],
  output logic                     vld_m,
  input  logic                     rdy_m,
  output logic [PLD_WIDTH-1:0]     pld_m,
  output logic                     last_m,
  output logic [$clog2(WIDTH)-1:0] src_m
);

  localparam int unsigned IW = idx_w(WIDTH);

  arb_st_e              state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, lock_q, lock_d;
  logic [WGT_W-1:0]     cred_q [WIDTH];
  logic [WGT_W-1:0]     cred_d [WIDTH];
  logic [WIDTH-1:0]     elig, pick_req, pick_gnt, grant;
  logic                 accept, reload, xfer, x_last;
  logic [IW-1:0]        gidx, next_idx;
  logic [PLD_WIDTH-1:0] mux_pld;

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      elig[i] = v_vld_s[i] & (cred_q[i] != '0);
    end
  end

  assign accept   = ~vld_m | rdy_m;
  // Round exhausted but someone is waiting: refill and arbitrate over raw valids this cycle.
  assign reload   = (state_q == ARB) & ~|elig & |v_vld_s;
  assign pick_req = reload ? v_vld_s : elig;

  arb_ptr_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .gnt (pick_gnt)
  );

  always_comb begin
    grant = '0;
    if (state_q == LOCK) begin
      grant[lock_q] = 1'b1;
    end else begin
      grant = pick_gnt;
    end
  end

  assign v_rdy_s = rst ? '0 : (grant & {WIDTH{accept}});
  assign xfer    = |(v_vld_s & v_rdy_s);

  // real_mux_onehot: AND-OR select of the granted requester's beat.
  always_comb begin
    gidx    = '0;
    x_last  = 1'b0;
    mux_pld = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      gidx    = gidx | ({IW{grant[i]}} & IW'(i));
      x_last  = x_last | (grant[i] & v_last_s[i]);
      mux_pld = mux_pld | ({PLD_WIDTH{grant[i]}} & v_pld_s[i]);
    end
  end

  assign next_idx = (gidx == IW'(WIDTH - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (reload && accept) begin
        cred_d[i] = (cfg_weight[i] == '0) ? WGT_W'(1) : cfg_weight[i];
      end else begin
        cred_d[i] = cred_q[i];
      end
    end
    if (xfer) begin
      if (!x_last) begin
        state_d = LOCK;
        lock_d  = gidx;
      end else begin
        state_d = ARB;
        if (cred_d[gidx] != '0) begin
          cred_d[gidx] = cred_d[gidx] - 1'b1;
        end
        // Requester with credit left keeps top priority for its next packet.
        ptr_d = (cred_d[gidx] == '0) ? next_idx : gidx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      lock_q  <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cred_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cred_q  <= cred_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_m  <= 1'b0;
      pld_m  <= '0;
      last_m <= 1'b0;
      src_m  <= '0;
    end else if (xfer) begin
      vld_m  <= 1'b1;
      pld_m  <= mux_pld;
      last_m <= x_last;
      src_m  <= gidx;
    end else if (rdy_m) begin
      vld_m  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_wrr_pkt.sv
// Self-checking bench for arb_wrr_pkt: table-driven arbitration orders plus lock, stall and reset cases.
module tb_arb_wrr_pkt;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned PLD_WIDTH = 32;
  localparam int unsigned WGT_W     = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WIDTH-1:0]     v_vld_s, v_rdy_s, v_last_s;
  logic [PLD_WIDTH-1:0] v_pld_s    [WIDTH-1:0];
  logic [WGT_W-1:0]     cfg_weight [WIDTH-1:0];
  logic                 vld_m, rdy_m, last_m;
  logic [PLD_WIDTH-1:0] pld_m;
  logic [1:0]           src_m;

  always #5 clk = ~clk;

  arb_wrr_pkt #(
    .WIDTH     (WIDTH),
    .PLD_WIDTH (PLD_WIDTH),
    .WGT_W     (WGT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .v_vld_s    (v_vld_s),
    .v_rdy_s    (v_rdy_s),
    .v_pld_s    (v_pld_s),
    .v_last_s   (v_last_s),
    .cfg_weight (cfg_weight),
    .vld_m      (vld_m),
    .rdy_m      (rdy_m),
    .pld_m      (pld_m),
    .last_m     (last_m),
    .src_m      (src_m)
  );

  // Nibble i of wgt/plen belongs to requester i; exp lists output sources left to right.
  typedef struct packed {
    logic [15:0] wgt;
    logic [3:0]  vmask;
    logic [15:0] plen;
    logic [47:0] exp;
  } vec_t;

  typedef logic [34:0] beat_t;  // {src, last, pld}

  vec_t       tbl [7];
  beat_t      sb_q [$];
  logic [1:0] exp_q [$];
  logic [3:0] en, gap;
  int         plen [WIDTH];
  int         bidx [WIDTH];
  int         seq  [WIDTH];
  int         done [WIDTH];
  int         checks = 0;
  int         errors = 0;
  logic       pend, seen_out, bubble_on;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(WIDTH); i++) begin
      v_vld_s[i]  = en[i] & ~gap[i];
      v_pld_s[i]  = {8'(i), 24'(seq[i])};
      v_last_s[i] = (bidx[i] == plen[i] - 1);
    end
  endtask

  task automatic set_cfg(input logic [15:0] w, input logic [15:0] p);
    for (int i = 0; i < int'(WIDTH); i++) begin
      cfg_weight[i] = w[4*i +: 4];
      plen[i]       = int'(p[4*i +: 4]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    exp_q.delete();
    for (int i = 0; i < int'(WIDTH); i++) begin
      bidx[i] = 0;
      done[i] = 0;
    end
    pend     = 1'b0;
    seen_out = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic tick();
    logic [3:0] xm;
    beat_t      nb;
    @(negedge clk);
    if (pend) chk("latency", 64'(vld_m), 1);
    if (bubble_on && seen_out && exp_q.size() > 0) chk("no_bubble", 64'(vld_m), 1);
    if (vld_m && rdy_m) begin
      seen_out = 1'b1;
      chk("sb_nonempty", 64'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        beat_t e = sb_q.pop_front();
        chk("beat", 64'({src_m, last_m, pld_m}), 64'(e));
      end
      if (exp_q.size() > 0) chk("src_order", 64'(src_m), 64'(exp_q.pop_front()));
    end
    xm = v_vld_s & v_rdy_s;
    if (xm != '0) chk("xfer_onehot", 64'($onehot(xm)), 1);
    nb = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (xm[i]) nb = {2'(i), v_last_s[i], v_pld_s[i]};
    end
    @(posedge clk);
    #1;
    pend = (xm != '0);
    if (pend) sb_q.push_back(nb);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (xm[i]) begin
        done[i]++;
        seq[i]++;
        bidx[i] = nb[32] ? 0 : bidx[i] + 1;
      end
    end
    drive();
  endtask

  task automatic run_exp(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("exp_drained", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_done(input int idx, input int cnt, input string name);
    int n = 0;
    while (done[idx] < cnt && n < 20) begin
      tick();
      n++;
    end
    chk(name, 64'(done[idx]), 64'(cnt));
  endtask

  task automatic drain();
    en = '0;
    drive();
    repeat (3) tick();
    chk("sb_drained", 64'(sb_q.size()), 0);
    chk("idle_vld", 64'(vld_m), 0);
  endtask

  task automatic push_exp(input logic [1:0] s);
    exp_q.push_back(s);
  endtask

  initial begin
    logic [PLD_WIDTH-1:0] hold_pld;
    logic [1:0]           hold_src;

    tbl[0] = '{wgt: 16'h1111, vmask: 4'hf,    plen: 16'h1111, exp: 48'h0123_0123_0123};
    tbl[1] = '{wgt: 16'h1113, vmask: 4'hf,    plen: 16'h1111, exp: 48'h0001_2300_0123};
    tbl[2] = '{wgt: 16'h2121, vmask: 4'hf,    plen: 16'h1111, exp: 48'h0112_3301_1233};
    tbl[3] = '{wgt: 16'h1111, vmask: 4'b1010, plen: 16'h1111, exp: 48'h1313_1313_1313};
    tbl[4] = '{wgt: 16'h0200, vmask: 4'hf,    plen: 16'h1111, exp: 48'h0122_3012_2301};
    tbl[5] = '{wgt: 16'h1111, vmask: 4'hf,    plen: 16'h2222, exp: 48'h0011_2233_0011};
    tbl[6] = '{wgt: 16'h1111, vmask: 4'b0011, plen: 16'h0014, exp: 48'h0000_1000_0100};

    for (int i = 0; i < int'(WIDTH); i++) seq[i] = 0;
    en        = 4'hf;
    gap       = '0;
    rdy_m     = 1'b1;
    bubble_on = 1'b0;
    set_cfg(16'h1111, 16'h1111);
    rst = 1'b1;
    drive();
    #3;
    chk("rst_vld", 64'(vld_m), 0);
    chk("rst_pld", 64'(pld_m), 0);
    chk("rst_last", 64'(last_m), 0);
    chk("rst_src", 64'(src_m), 0);
    chk("rst_rdy", 64'(v_rdy_s), 0);

    bubble_on = 1'b1;
    for (int t = 0; t < 7; t++) begin
      do_reset();
      set_cfg(tbl[t].wgt, tbl[t].plen);
      en    = tbl[t].vmask;
      gap   = '0;
      rdy_m = 1'b1;
      drive();
      for (int k = 0; k < 12; k++) push_exp(tbl[t].exp[44-4*k +: 2]);
      run_exp(80);
      drain();
    end
    bubble_on = 1'b0;

    // Locked requester 2 pauses mid-packet; others must not be granted.
    do_reset();
    set_cfg(16'h1111, 16'h1411);
    en = 4'b0100;
    drive();
    push_exp(2); push_exp(2); push_exp(2); push_exp(2); push_exp(0); push_exp(1);
    wait_done(2, 1, "lock_start");
    en  = 4'b0111;
    gap = 4'b0100;
    drive();
    repeat (3) begin
      #1 chk("gap_rdy", 64'(v_rdy_s), 64'(4'b0100));
      tick();
    end
    gap = '0;
    drive();
    run_exp(40);
    drain();

    // Output back-pressure holds the registered beat and blocks all inputs.
    do_reset();
    set_cfg(16'h1111, 16'h1111);
    en = 4'hf;
    drive();
    repeat (3) begin
      push_exp(0); push_exp(1); push_exp(2); push_exp(3);
    end
    repeat (4) tick();
    rdy_m = 1'b0;
    #1;
    hold_pld = pld_m;
    hold_src = src_m;
    chk("stall_vld", 64'(vld_m), 1);
    repeat (5) begin
      tick();
      #1;
      chk("stall_pld", 64'(pld_m), 64'(hold_pld));
      chk("stall_src", 64'(src_m), 64'(hold_src));
      chk("stall_rdy", 64'(v_rdy_s), 0);
    end
    rdy_m = 1'b1;
    run_exp(60);
    drain();

    // Reset while locked; pointer and credits must restart from zero.
    do_reset();
    set_cfg(16'h1111, 16'h1114);
    en = 4'b0010;
    drive();
    wait_done(1, 1, "pre_lock_beat");
    en = 4'b0001;
    drive();
    wait_done(0, 2, "locked_beats");
    #2 rst = 1'b1;
    #1;
    chk("midrst_vld", 64'(vld_m), 0);
    chk("midrst_rdy", 64'(v_rdy_s), 0);
    chk("midrst_src", 64'(src_m), 0);
    do_reset();
    set_cfg(16'h1111, 16'h1111);
    en = 4'b1110;
    drive();
    push_exp(1); push_exp(2); push_exp(3); push_exp(1); push_exp(2); push_exp(3);
    run_exp(40);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
